// File: rtl/p_instruction.sv
// Shared instruction-level types for the shift execution path.
package p_instruction;

  localparam int unsigned SHIFT_AMOUNT_W = 5;

  typedef enum logic [2:0] {
    SHIFT_SHL = 3'd0,
    SHIFT_SHR = 3'd1,
    SHIFT_SAR = 3'd2,
    SHIFT_ROL = 3'd3,
    SHIFT_ROR = 3'd4
  } e_shift_op;

  // Amount field is sized for a 32-bit datapath.
  typedef struct packed {
    e_shift_op                 op;
    logic [SHIFT_AMOUNT_W-1:0] amount;
  } s_shift;

endpackage

// File: rtl/m_shift_step.sv
// One combinational shift/rotate step of 0..STEP positions, with carry-out.
module m_shift_step
  import p_instruction::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  parameter int unsigned KW    = $clog2(STEP + 1)
) (
  input  e_shift_op        op,
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  input  logic             sign,
  output logic [WIDTH-1:0] shifted,
  output logic             carry_out
);

  int unsigned          kn;
  logic [2*WIDTH-1:0]   ext;
  logic [WIDTH-1:0]     lo_out;
  logic [WIDTH-1:0]     hi_out;

  // Shift by k per op; carry is the last bit to leave (the wrapped bit for rotates).
  always_comb begin
    kn        = int'(k);
    ext       = '0;
    // lo_out[0] is the last bit leaving on the right, hi_out[WIDTH-1] on the left.
    lo_out    = data >> (kn - 1);
    hi_out    = data << (kn - 1);
    shifted   = data << k;
    carry_out = (kn != 0) ? hi_out[WIDTH-1] : 1'b0;
    case (op)
      SHIFT_SHR: begin
        shifted   = data >> k;
        carry_out = (kn != 0) ? lo_out[0] : 1'b0;
      end
      SHIFT_SAR: begin
        ext       = {{WIDTH{sign}}, data} >> k;
        shifted   = ext[WIDTH-1:0];
        carry_out = (kn != 0) ? lo_out[0] : 1'b0;
      end
      SHIFT_ROL: begin
        shifted   = (data << k) | (data >> (WIDTH - kn));
        carry_out = (kn != 0) ? hi_out[WIDTH-1] : 1'b0;
      end
      SHIFT_ROR: begin
        shifted   = (data >> k) | (data << (WIDTH - kn));
        carry_out = (kn != 0) ? lo_out[0] : 1'b0;
      end
      default: ;  // SHL and unknown encodings
    endcase
  end

endmodule

// File: rtl/m_shift_unit.sv
// Multi-cycle shift/rotate unit: accepts one operand, shifts up to STEP bits per
// cycle, then holds the result until the consumer takes it.
module m_shift_unit
  import p_instruction::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  s_shift           shift,
  input  logic [WIDTH-1:0] value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int unsigned AW = $clog2(WIDTH);
  localparam int unsigned KW = $clog2(STEP + 1);
  localparam logic [AW:0] STEP_L = STEP[AW:0];

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("m_shift_unit: WIDTH must be a power of two >= 8");
  end
  if (STEP < 1 || STEP > WIDTH || (STEP & (STEP - 1)) != 0) begin : g_bad_step
    $error("m_shift_unit: STEP must be a power of two in 1..WIDTH");
  end

  logic [1:0]       state_q, state_d;
  e_shift_op        op_q, op_d, op_in;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic [AW-1:0]    rem_q, rem_d, rem_next;
  logic             sign_q, sign_d;
  logic [AW-1:0]    amount;
  logic [AW:0]      k_full;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  assign amount = AW'(shift.amount);

  // Unknown op encodings are folded to SHL at capture time.
  always_comb begin
    case (shift.op)
      SHIFT_SHR, SHIFT_SAR, SHIFT_ROL, SHIFT_ROR: op_in = shift.op;
      default:                                    op_in = SHIFT_SHL;
    endcase
  end

  // Step size this cycle: min(rem, STEP).
  always_comb begin
    k_full   = ({1'b0, rem_q} < STEP_L) ? {1'b0, rem_q} : STEP_L;
    k        = KW'(k_full);
    rem_next = rem_q - AW'(k_full);
  end

  m_shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .op        (op_q),
    .data      (data_q),
    .k         (k),
    .sign      (sign_q),
    .shifted   (step_data),
    .carry_out (step_carry)
  );

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    carry_d = carry_q;
    rem_d   = rem_q;
    sign_d  = sign_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d    = op_in;
            data_d  = value;
            rem_d   = amount;
            carry_d = 1'b0;
            sign_d  = value[WIDTH-1];
            state_d = (amount == '0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          data_d  = step_data;
          carry_d = step_carry;
          rem_d   = rem_next;
          if (rem_next == '0) state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= SHIFT_SHL;
      data_q  <= '0;
      carry_q <= 1'b0;
      rem_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      rem_q   <= rem_d;
      sign_q  <= sign_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = data_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_m_shift_unit.sv
// Scoreboard bench for m_shift_unit (WIDTH=32, STEP=4).
module tb_m_shift_unit;
  import p_instruction::*;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, carry;
  s_shift      shift;
  logic [31:0] value, result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  bit exp_rdy = 0;

  typedef struct {
    logic [31:0] res;
    logic        c;
    int          acc;
    int          lat;
    bit          seen;
  } exp_t;
  exp_t q[$];

  m_shift_unit #(.WIDTH(32), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .shift     (shift),
    .value     (value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: apply the operation one bit position at a time.
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] v, input int amt,
                                    output logic [31:0] r, output logic c);
    r = v;
    c = 1'b0;
    for (int i = 0; i < amt; i++) begin
      case (op)
        3'd1: begin c = r[0];  r = {1'b0, r[31:1]}; end
        3'd2: begin c = r[0];  r = {r[31], r[31:1]}; end
        3'd3: begin c = r[31]; r = {r[30:0], r[31]}; end
        3'd4: begin c = r[0];  r = {r[0], r[31:1]}; end
        default: begin c = r[31]; r = {r[30:0], 1'b0}; end
      endcase
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] v, input int amt);
    exp_t e;
    int   n = 0;
    bit   done = 0;
    in_valid     = 1;
    shift.op     = e_shift_op'(op);
    shift.amount = amt[4:0];
    value        = v;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        ref_model(op, v, amt, e.res, e.c);
        e.acc  = cyc;
        e.lat  = (amt + 3) / 4;
        e.seen = 0;
        q.push_back(e);
        done = 1;
      end else if (++n > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: in_ready never rose (cycle %0d)", cyc);
        done = 1;
      end
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  // out_ready driver
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 0;
      endcase
    end
  end

  // Monitor: compare every presented result against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_rdy = 0;
      end else begin
        if (exp_rdy) begin
          chk("in_ready_after_release", 32'(in_ready), 32'd1);
          exp_rdy = 0;
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            if (!q[0].seen) begin
              chk("latency_cycle", 32'(cyc), 32'(q[0].acc + 1 + q[0].lat));
              q[0].seen = 1;
            end
            chk("result", result, q[0].res);
            chk("carry", 32'(carry), 32'(q[0].c));
            chk("in_ready_low_while_done", 32'(in_ready), 32'd0);
            if (out_ready) begin
              void'(q.pop_front());
              exp_rdy = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n    = 0;
    flush    = 0;
    in_valid = 0;
    shift    = '0;
    value    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_carry", 32'(carry), 32'd0);
    @(posedge clk);
    #1;

    // Directed cases
    issue(3'd0, 32'h0000_0001, 5);  drain();
    issue(3'd2, 32'h8000_0000, 31); drain();
    issue(3'd1, 32'h8000_0000, 31); drain();
    issue(3'd4, 32'h0000_0001, 1);  drain();
    issue(3'd3, 32'h8000_0000, 4);  drain();
    issue(3'd6, 32'h0000_00F1, 7);  drain();

    // Zero amount with back-pressure held for three cycles
    rdy_mode = 2;
    issue(3'd1, 32'hDEAD_BEEF, 0);
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    drain();

    // Flush two cycles after accept
    issue(3'd0, 32'h1234_5678, 20);
    @(posedge clk);
    #1 flush = 1;
    q.delete();
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    chk("in_ready_after_flush", 32'(in_ready), 32'd1);
    chk("out_valid_after_flush", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    issue(3'd0, 32'h0000_0001, 2);
    drain();

    // Asynchronous reset while busy
    issue(3'd0, $urandom, 31);
    @(posedge clk);
    #2 rst_n = 0;
    q.delete();
    #1;
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_carry", 32'(carry), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    issue(3'd2, 32'hF00F_0F0F, 13);
    drain();

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      rdy_mode = $urandom_range(0, 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      issue(3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 31));
    end
    rdy_mode = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
